// File: rtl/mem_bus_responder.sv
// mem_bus_responder: word memory answering MEM_r_w_z_z with an MFC handshake, wait states and a range error
module mem_bus_responder #(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        MEM_Clock,
    input  logic        MEM_Reset_L,
    input  logic [31:0] MEM_Address,
    input  logic [31:0] MEM_Data_In,
    input  logic [1:0]  MEM_r_w_z_z,
    output logic [31:0] MEM_Data_Out,
    output logic        MEM_MFC,
    output logic        MEM_ERROR,
    output logic        MEM_Busy
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, ACK = 2'd2;
    logic [1:0]  state;
    logic [3:0]  cnt;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        op_w;
    logic        in_range;
    logic        done;
    logic [31:0] mem [DEPTH];
    assign in_range = addr < 32'(DEPTH);
    assign done     = state == BUSY && cnt == 4'd0;
    assign MEM_Busy = state != IDLE;
    // RAM write port; left without reset so the array maps onto block memory
    always_ff @(posedge MEM_Clock)
        if (done && op_w && in_range) mem[addr[AW-1:0]] <= wdata;
    // capture request, count down wait states, perform access, hold until the bus is released
    always_ff @(posedge MEM_Clock or negedge MEM_Reset_L)
        if (!MEM_Reset_L) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            addr         <= 32'd0;
            wdata        <= 32'd0;
            op_w         <= 1'b0;
            MEM_Data_Out <= 32'd0;
            MEM_MFC      <= 1'b0;
            MEM_ERROR    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (!MEM_r_w_z_z[1]) begin
                    addr  <= MEM_Address;
                    wdata <= MEM_Data_In;
                    op_w  <= MEM_r_w_z_z[0];
                    cnt   <= 4'(WAIT_CYCLES);
                    state <= BUSY;
                end
                BUSY: if (cnt != 4'd0) cnt <= cnt - 4'd1;
                else begin
                    state        <= ACK;
                    MEM_MFC      <= 1'b1;
                    MEM_ERROR    <= !in_range;
                    MEM_Data_Out <= !in_range ? 32'd0 : op_w ? wdata : mem[addr[AW-1:0]];
                end
                ACK: if (MEM_r_w_z_z[1]) begin
                    state        <= IDLE;
                    MEM_MFC      <= 1'b0;
                    MEM_ERROR    <= 1'b0;
                    MEM_Data_Out <= 32'd0;
                end
                default: state <= IDLE;
            endcase
        end
endmodule
